// File: rtl/beat_sequencer_pkg.sv
// Shared types and constants for the hardwired-controller beat sequencer.
package beat_sequencer_pkg;

   localparam int unsigned QD_SYNC_STAGES_DEF = 2;
   localparam int unsigned BEAT_CNT_W_DEF     = 8;

   typedef enum logic [1:0] {
      BEAT_W1 = 2'd0,
      BEAT_W2 = 2'd1,
      BEAT_W3 = 2'd2
   } beat_t;

   typedef enum logic [1:0] {
      PH_T1 = 2'd0,
      PH_T2 = 2'd1,
      PH_T3 = 2'd2
   } phase_t;

   typedef enum logic {
      ST_PARK = 1'b0,
      ST_RUN  = 1'b1
   } seq_state_t;

endpackage

// File: rtl/beat_sequencer_qd_sync.sv
// Start-button synchroniser with a single-cycle rising-edge pulse.
module beat_sequencer_qd_sync
   import beat_sequencer_pkg::*;
#(
   parameter int unsigned STAGES = QD_SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic clr,
   input  logic qd,
   output logic rise_c
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] vld_q;
   logic              prev_q;
   logic              armed_q;

   // armed_q only sets once a genuine low sample of QD has left the chain,
   // so a button held through clr release never looks like a press.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q  <= '0;
         vld_q   <= '0;
         prev_q  <= 1'b0;
         armed_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[STAGES-2:0], qd};
         vld_q   <= {vld_q[STAGES-2:0], 1'b1};
         prev_q  <= sync_q[STAGES-1];
         armed_q <= armed_q | (vld_q[STAGES-1] & ~sync_q[STAGES-1]);
      end
   end

   assign rise_c = sync_q[STAGES-1] & ~prev_q & armed_q;

endmodule

// File: rtl/beat_sequencer.sv
// Beat/phase timing generator: W1..W3 beat levels, T1..T3 phase strobes,
// park/run control from the panel start button and controller requests.
module beat_sequencer
   import beat_sequencer_pkg::*;
#(
   parameter int unsigned QD_SYNC_STAGES = QD_SYNC_STAGES_DEF,
   parameter int unsigned BEAT_CNT_W     = BEAT_CNT_W_DEF
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  QD,
   input  logic                  STEP,
   input  logic                  SHORT,
   input  logic                  LONG,
   input  logic                  STOP,
   output logic                  T1,
   output logic                  T2,
   output logic                  T3,
   output logic                  W1,
   output logic                  W2,
   output logic                  W3,
   output logic                  RUN,
   output logic [BEAT_CNT_W-1:0] BEATS
);

   seq_state_t            state_q, state_n;
   beat_t                 beat_q, beat_n, nb_c;
   phase_t                phase_q, phase_n;
   logic [BEAT_CNT_W-1:0] beats_q, beats_n;
   logic                  qd_rise_c;

   beat_sequencer_qd_sync #(
      .STAGES (QD_SYNC_STAGES)
   ) u_qd_sync (
      .clk    (clk),
      .clr    (clr),
      .qd     (QD),
      .rise_c (qd_rise_c)
   );

   // Next state, beat and phase; controller requests only matter at T3.
   always_comb begin
      state_n = state_q;
      beat_n  = beat_q;
      phase_n = phase_q;
      beats_n = beats_q;
      nb_c    = BEAT_W1;
      case (state_q)
         ST_PARK: begin
            if (qd_rise_c) begin
               state_n = ST_RUN;
               beat_n  = BEAT_W1;
               phase_n = PH_T1;
            end
         end
         ST_RUN: begin
            case (phase_q)
               PH_T1:   phase_n = PH_T2;
               PH_T2:   phase_n = PH_T3;
               default: begin
                  phase_n = PH_T1;
                  beats_n = beats_q + BEAT_CNT_W'(1);
                  case (beat_q)
                     BEAT_W1: nb_c = SHORT ? BEAT_W1 : BEAT_W2;
                     BEAT_W2: nb_c = LONG  ? BEAT_W3 : BEAT_W1;
                     default: nb_c = BEAT_W1;
                  endcase
                  if (STOP) nb_c = BEAT_W1;
                  beat_n = nb_c;
                  if (STOP || (STEP && (nb_c == BEAT_W1))) state_n = ST_PARK;
               end
            endcase
         end
         default: state_n = ST_PARK;
      endcase
   end

   // State plus one-hot outputs registered from next-state decode (glitch-free).
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q <= ST_PARK;
         beat_q  <= BEAT_W1;
         phase_q <= PH_T1;
         beats_q <= '0;
         W1      <= 1'b1;
         W2      <= 1'b0;
         W3      <= 1'b0;
         T1      <= 1'b0;
         T2      <= 1'b0;
         T3      <= 1'b0;
         RUN     <= 1'b0;
      end else begin
         state_q <= state_n;
         beat_q  <= beat_n;
         phase_q <= phase_n;
         beats_q <= beats_n;
         W1      <= (beat_n == BEAT_W1);
         W2      <= (beat_n == BEAT_W2);
         W3      <= (beat_n == BEAT_W3);
         T1      <= (state_n == ST_RUN) && (phase_n == PH_T1);
         T2      <= (state_n == ST_RUN) && (phase_n == PH_T2);
         T3      <= (state_n == ST_RUN) && (phase_n == PH_T3);
         RUN     <= (state_n == ST_RUN);
      end
   end

   assign BEATS = beats_q;

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed self-checking bench for beat_sequencer.
module tb_beat_sequencer;
   import beat_sequencer_pkg::*;

   localparam int unsigned LAT = QD_SYNC_STAGES_DEF;
   localparam logic [6:0] PARK_V = 7'b0100000;
   localparam logic [2:0] W_1 = 3'b100, W_2 = 3'b010, W_3 = 3'b001;
   localparam logic [2:0] T_1 = 3'b100, T_2 = 3'b010, T_3 = 3'b001;

   logic       clk = 1'b0;
   logic       clr, QD, STEP, SHORT, LONG, STOP;
   logic       T1, T2, T3, W1, W2, W3, RUN;
   logic [7:0] BEATS;
   logic [6:0] obs;
   int         checks = 0;
   int         errors = 0;

   beat_sequencer #(
      .QD_SYNC_STAGES (QD_SYNC_STAGES_DEF),
      .BEAT_CNT_W     (8)
   ) dut (
      .clk   (clk),
      .clr   (clr),
      .QD    (QD),
      .STEP  (STEP),
      .SHORT (SHORT),
      .LONG  (LONG),
      .STOP  (STOP),
      .T1    (T1),
      .T2    (T2),
      .T3    (T3),
      .W1    (W1),
      .W2    (W2),
      .W3    (W3),
      .RUN   (RUN),
      .BEATS (BEATS)
   );

   always #5 clk = ~clk;

   assign obs = {RUN, W1, W2, W3, T1, T2, T3};

   function automatic logic [6:0] rv(input logic [2:0] w, input logic [2:0] t);
      return {1'b1, w, t};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string tag, input logic [6:0] e);
      checks++;
      assert (obs === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b (RUN W1W2W3 T1T2T3)", tag, obs, e);
      end
   endtask

   task automatic chk_beats(input string tag, input logic [7:0] e);
      checks++;
      assert (BEATS === e) else begin
         errors++;
         $error("FAIL %s observed BEATS=%0d expected=%0d", tag, BEATS, e);
      end
   endtask

   // Controller inputs outside T3 must be ignored, so scramble them.
   task automatic junk();
      SHORT = 1'($urandom);
      LONG  = 1'($urandom);
      STOP  = 1'($urandom);
      STEP  = 1'($urandom);
   endtask

   // Checks one full beat starting at its T1, applies requests at T3.
   task automatic beat(input string tag, input logic [2:0] w, input logic [7:0] b,
                       input logic s, input logic l, input logic p, input logic st);
      chk({tag, "_t1"}, rv(w, T_1));
      chk_beats({tag, "_cnt"}, b);
      junk();
      tick();
      chk({tag, "_t2"}, rv(w, T_2));
      junk();
      tick();
      chk({tag, "_t3"}, rv(w, T_3));
      SHORT = s;
      LONG  = l;
      STOP  = p;
      STEP  = st;
      tick();
   endtask

   initial begin
      clr = 1'b1; QD = 1'b0; STEP = 1'b0; SHORT = 1'b0; LONG = 1'b0; STOP = 1'b0;
      #2;
      chk("reset", PARK_V);
      chk_beats("reset_cnt", 8'd0);
      ticks(2);
      clr = 1'b0;
      tick();
      chk("idle", PARK_V);

      // Start press: RUN appears LAT edges after QD is first sampled.
      QD = 1'b1;
      ticks(LAT);
      chk("qd_lat_early", PARK_V);
      tick();
      QD = 1'b0;
      for (int i = 0; i < 6; i++)
         beat("run", (i % 2 == 1) ? W_2 : W_1, 8'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      chk("run6", rv(W_1, T_1));
      chk_beats("run6_cnt", 8'd6);

      beat("short0", W_1, 8'd6,  1'b1, 1'b0, 1'b0, 1'b0);
      beat("short1", W_1, 8'd7,  1'b1, 1'b0, 1'b0, 1'b0);
      beat("w1_long", W_1, 8'd8, 1'b0, 1'b1, 1'b0, 1'b0);
      beat("w2_long", W_2, 8'd9, 1'b0, 1'b1, 1'b0, 1'b0);
      beat("w3",     W_3, 8'd10, 1'b0, 1'b1, 1'b0, 1'b0);
      beat("both",   W_1, 8'd11, 1'b1, 1'b1, 1'b0, 1'b0);
      beat("w1n",    W_1, 8'd12, 1'b0, 1'b0, 1'b0, 1'b0);
      beat("stop",   W_2, 8'd13, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("stop_park", PARK_V);
      chk_beats("stop_cnt", 8'd14);
      STOP = 1'b0; LONG = 1'b0;
      ticks(4);
      chk("stay_park", PARK_V);

      // Single-step: park after each instruction; presses during RUN are dropped.
      STEP = 1'b1;
      QD = 1'b1;
      ticks(LAT + 1);
      QD = 1'b0;
      beat("step_w1", W_1, 8'd14, 1'b0, 1'b0, 1'b0, 1'b1);
      QD = 1'b1;
      beat("step_w2", W_2, 8'd15, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("step_park", PARK_V);
      chk_beats("step_cnt", 8'd16);
      ticks(6);
      chk("press_ignored", PARK_V);
      QD = 1'b0;
      ticks(LAT + 1);
      QD = 1'b1;
      ticks(LAT);
      chk("resume_early", PARK_V);
      tick();
      beat("resume", W_1, 8'd16, 1'b0, 1'b0, 1'b0, 1'b0);
      beat("pre_w3", W_2, 8'd17, 1'b0, 1'b1, 1'b0, 1'b0);
      chk("w3_t1", rv(W_3, T_1));
      tick();
      chk("w3_t2", rv(W_3, T_2));

      // Asynchronous clear mid-beat, QD still held high.
      #3;
      clr = 1'b1;
      #1;
      chk("clr_async", PARK_V);
      chk_beats("clr_cnt", 8'd0);
      LONG = 1'b0;
      ticks(2);
      clr = 1'b0;
      ticks(LAT + 4);
      chk("qd_held", PARK_V);
      QD = 1'b0;
      ticks(LAT + 1);
      QD = 1'b1;
      ticks(LAT);
      chk("rearm_early", PARK_V);
      tick();
      chk("rearm_run", rv(W_1, T_1));
      chk_beats("rearm_cnt", 8'd0);

      // Counter wrap with continuous short instructions.
      SHORT = 1'b1; LONG = 1'b0; STOP = 1'b0; STEP = 1'b0;
      ticks(3 * 255);
      chk("wrap_255", rv(W_1, T_1));
      chk_beats("wrap_255_cnt", 8'd255);
      ticks(3);
      chk("wrap_0", rv(W_1, T_1));
      chk_beats("wrap_0_cnt", 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
